// File: rtl/alu_rs.sv
// alu_rs: reservation station for the integer ALU. Operands are resolved by snooping two
// result buses; the lowest-index ready entry is dispatched each cycle and its result broadcast.
module alu_rs #(
    parameter int unsigned RS_SIZE = 8,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned OP_W    = 6
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             clear_in,
    input  logic             issue_valid,
    input  logic [OP_W-1:0]  issue_op,
    input  logic [31:0]      issue_vj,
    input  logic [31:0]      issue_vk,
    input  logic             issue_qj_pend,
    input  logic             issue_qk_pend,
    input  logic [TAG_W-1:0] issue_qj,
    input  logic [TAG_W-1:0] issue_qk,
    input  logic [TAG_W-1:0] issue_dest,
    output logic             full_out,
    input  logic             cdb_a_valid,
    input  logic [TAG_W-1:0] cdb_a_tag,
    input  logic [31:0]      cdb_a_value,
    input  logic             cdb_b_valid,
    input  logic [TAG_W-1:0] cdb_b_tag,
    input  logic [31:0]      cdb_b_value,
    output logic [31:0]      alu_rs1,
    output logic [31:0]      alu_rs2,
    output logic [OP_W-1:0]  alu_op,
    input  logic [31:0]      alu_result,
    input  logic             alu_valid,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag,
    output logic [31:0]      out_value
);
    localparam int unsigned IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    logic [RS_SIZE-1:0] r_busy;
    logic [RS_SIZE-1:0] r_qj_pend;
    logic [RS_SIZE-1:0] r_qk_pend;
    logic [OP_W-1:0]    r_op   [RS_SIZE];
    logic [31:0]        r_vj   [RS_SIZE];
    logic [31:0]        r_vk   [RS_SIZE];
    logic [TAG_W-1:0]   r_qj   [RS_SIZE];
    logic [TAG_W-1:0]   r_qk   [RS_SIZE];
    logic [TAG_W-1:0]   r_dest [RS_SIZE];

    logic               r_out_valid;
    logic [TAG_W-1:0]   r_out_tag;
    logic [31:0]        r_out_value;

    logic [RS_SIZE-1:0] w_ready;
    logic               w_sel_valid;
    logic [IDX_W-1:0]   w_sel_idx;
    logic [IDX_W-1:0]   w_free_idx;
    logic               w_insert;

    assign w_ready   = r_busy & ~r_qj_pend & ~r_qk_pend;
    assign full_out  = &r_busy;
    assign w_insert  = issue_valid && (issue_op != '0) && !full_out;
    assign out_valid = r_out_valid;
    assign out_tag   = r_out_tag;
    assign out_value = r_out_value;

    // Descending scan so the last hit (lowest index) wins for both encoders.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_idx   = '0;
        w_free_idx  = '0;
        for (int i = int'(RS_SIZE) - 1; i >= 0; i--) begin
            if (w_ready[i]) begin
                w_sel_valid = 1'b1;
                w_sel_idx   = IDX_W'(i);
            end
            if (!r_busy[i]) begin
                w_free_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        alu_rs1 = '0;
        alu_rs2 = '0;
        alu_op  = '0;
        if (w_sel_valid) begin
            alu_rs1 = r_vj[w_sel_idx];
            alu_rs2 = r_vk[w_sel_idx];
            alu_op  = r_op[w_sel_idx];
        end
    end

    // Returns {pend, value} after looking at both buses; bus A wins a double match.
    function automatic logic [32:0] f_capture(input logic             pend,
                                              input logic [TAG_W-1:0] tag,
                                              input logic [31:0]      value);
        logic [32:0] res;
        res = {pend, value};
        if (pend && cdb_a_valid && (tag == cdb_a_tag)) begin
            res = {1'b0, cdb_a_value};
        end else if (pend && cdb_b_valid && (tag == cdb_b_tag)) begin
            res = {1'b0, cdb_b_value};
        end
        return res;
    endfunction

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_busy      <= '0;
            r_qj_pend   <= '0;
            r_qk_pend   <= '0;
            r_out_valid <= 1'b0;
            r_out_tag   <= '0;
            r_out_value <= '0;
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                r_op[i]   <= '0;
                r_vj[i]   <= '0;
                r_vk[i]   <= '0;
                r_qj[i]   <= '0;
                r_qk[i]   <= '0;
                r_dest[i] <= '0;
            end
        end else if (rdy_in) begin
            if (clear_in) begin
                r_busy      <= '0;
                r_out_valid <= 1'b0;
            end else begin
                for (int i = 0; i < int'(RS_SIZE); i++) begin
                    if (r_busy[i]) begin
                        {r_qj_pend[i], r_vj[i]} <= f_capture(r_qj_pend[i], r_qj[i], r_vj[i]);
                        {r_qk_pend[i], r_vk[i]} <= f_capture(r_qk_pend[i], r_qk[i], r_vk[i]);
                    end
                end

                if (w_sel_valid) begin
                    r_busy[w_sel_idx] <= 1'b0;
                    r_out_valid       <= alu_valid;
                    r_out_tag         <= r_dest[w_sel_idx];
                    r_out_value       <= alu_result;
                end else begin
                    r_out_valid <= 1'b0;
                end

                // The free slot is never the dispatched one, so these writes cannot collide.
                if (w_insert) begin
                    r_busy[w_free_idx] <= 1'b1;
                    r_op[w_free_idx]   <= issue_op;
                    r_qj[w_free_idx]   <= issue_qj;
                    r_qk[w_free_idx]   <= issue_qk;
                    r_dest[w_free_idx] <= issue_dest;
                    {r_qj_pend[w_free_idx], r_vj[w_free_idx]} <=
                        f_capture(issue_qj_pend, issue_qj, issue_vj);
                    {r_qk_pend[w_free_idx], r_vk[w_free_idx]} <=
                        f_capture(issue_qk_pend, issue_qk, issue_vk);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed scenarios followed by a randomized run against an entry-list model
// of the reservation station, with a small ALU and bus-A loopback supplied by the bench.
module tb_alu_rs;
    localparam int RS = 8;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_ADDI = 6'd2;
    localparam logic [5:0] OP_SUB  = 6'd3;
    localparam logic [5:0] OP_XOR  = 6'd4;
    localparam logic [5:0] OP_AND  = 6'd5;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        clear_in = 1'b0;
    logic        issue_valid = 1'b0;
    logic [5:0]  issue_op = '0;
    logic [31:0] issue_vj = '0;
    logic [31:0] issue_vk = '0;
    logic        issue_qj_pend = 1'b0;
    logic        issue_qk_pend = 1'b0;
    logic [3:0]  issue_qj = '0;
    logic [3:0]  issue_qk = '0;
    logic [3:0]  issue_dest = '0;
    logic        cdb_b_valid = 1'b0;
    logic [3:0]  cdb_b_tag = '0;
    logic [31:0] cdb_b_value = '0;
    logic        tb_a_en = 1'b0;
    logic        tb_a_valid = 1'b0;
    logic [3:0]  tb_a_tag = '0;
    logic [31:0] tb_a_value = '0;

    logic        full_out;
    logic [31:0] alu_rs1;
    logic [31:0] alu_rs2;
    logic [5:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_valid;
    logic        out_valid;
    logic [3:0]  out_tag;
    logic [31:0] out_value;
    logic        cdb_a_valid;
    logic [3:0]  cdb_a_tag;
    logic [31:0] cdb_a_value;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] f_alu(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            OP_ADD, OP_ADDI: return a + b;
            OP_SUB:          return a - b;
            OP_XOR:          return a ^ b;
            OP_AND:          return a & b;
            default:         return 32'd0;
        endcase
    endfunction

    assign alu_result  = f_alu(alu_op, alu_rs1, alu_rs2);
    assign alu_valid   = (alu_op != 6'd0);
    assign cdb_a_valid = tb_a_en ? tb_a_valid : out_valid;
    assign cdb_a_tag   = tb_a_en ? tb_a_tag : out_tag;
    assign cdb_a_value = tb_a_en ? tb_a_value : out_value;

    alu_rs #(.RS_SIZE(8), .TAG_W(4), .OP_W(6)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .issue_valid(issue_valid), .issue_op(issue_op), .issue_vj(issue_vj),
        .issue_vk(issue_vk), .issue_qj_pend(issue_qj_pend), .issue_qk_pend(issue_qk_pend),
        .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_dest(issue_dest),
        .full_out(full_out), .cdb_a_valid(cdb_a_valid), .cdb_a_tag(cdb_a_tag),
        .cdb_a_value(cdb_a_value), .cdb_b_valid(cdb_b_valid), .cdb_b_tag(cdb_b_tag),
        .cdb_b_value(cdb_b_value), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_op(alu_op),
        .alu_result(alu_result), .alu_valid(alu_valid), .out_valid(out_valid),
        .out_tag(out_tag), .out_value(out_value)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_issue(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                             input logic pj, input logic [3:0] qj, input logic pk,
                             input logic [3:0] qk, input logic [3:0] dest);
        issue_valid = 1'b1;
        issue_op = op;
        issue_vj = vj;
        issue_vk = vk;
        issue_qj_pend = pj;
        issue_qj = qj;
        issue_qk_pend = pk;
        issue_qk = qk;
        issue_dest = dest;
    endtask

    task automatic no_issue();
        issue_valid = 1'b0;
        issue_op = '0;
    endtask

    // Model: a flat list of entries plus the broadcast register.
    typedef struct {
        bit          busy;
        logic [5:0]  op;
        logic [31:0] vj;
        logic [31:0] vk;
        bit          pj;
        bit          pk;
        logic [3:0]  qj;
        logic [3:0]  qk;
        logic [3:0]  dest;
    } ent_t;

    ent_t        m [RS];
    bit          m_ov;
    logic [3:0]  m_ot;
    logic [31:0] m_oval;

    function automatic int model_sel();
        for (int i = 0; i < RS; i++) begin
            if (m[i].busy && !m[i].pj && !m[i].pk) return i;
        end
        return -1;
    endfunction

    function automatic bit model_full();
        for (int i = 0; i < RS; i++) begin
            if (!m[i].busy) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic resolve(input bit pend, input logic [3:0] q, input logic [31:0] v,
                           output bit pend_o, output logic [31:0] v_o);
        pend_o = pend;
        v_o = v;
        if (pend && m_ov && q == m_ot) begin
            pend_o = 1'b0;
            v_o = m_oval;
        end else if (pend && cdb_b_valid && q == cdb_b_tag) begin
            pend_o = 1'b0;
            v_o = cdb_b_value;
        end
    endtask

    task automatic model_update();
        ent_t n [RS];
        int s;
        int f;
        if (!rdy_in) return;
        if (clear_in) begin
            for (int i = 0; i < RS; i++) m[i].busy = 1'b0;
            m_ov = 1'b0;
            return;
        end
        n = m;
        s = model_sel();
        f = -1;
        for (int i = RS - 1; i >= 0; i--) if (!m[i].busy) f = i;
        for (int i = 0; i < RS; i++) begin
            if (m[i].busy) begin
                resolve(m[i].pj, m[i].qj, m[i].vj, n[i].pj, n[i].vj);
                resolve(m[i].pk, m[i].qk, m[i].vk, n[i].pk, n[i].vk);
            end
        end
        if (f >= 0 && issue_valid && issue_op != 6'd0) begin
            n[f].busy = 1'b1;
            n[f].op = issue_op;
            n[f].qj = issue_qj;
            n[f].qk = issue_qk;
            n[f].dest = issue_dest;
            resolve(issue_qj_pend, issue_qj, issue_vj, n[f].pj, n[f].vj);
            resolve(issue_qk_pend, issue_qk, issue_vk, n[f].pk, n[f].vk);
        end
        if (s >= 0) begin
            n[s].busy = 1'b0;
            m_ov = 1'b1;
            m_ot = m[s].dest;
            m_oval = f_alu(m[s].op, m[s].vj, m[s].vk);
        end else begin
            m_ov = 1'b0;
        end
        m = n;
    endtask

    initial begin
        int s;
        tick();
        tick();
        rst_in = 1'b0;
        check("rst_full", 32'(full_out), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_out_value", out_value, 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);

        // Single ready Addi.
        set_issue(OP_ADDI, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
        tick();
        no_issue();
        check("addi_op", 32'(alu_op), 32'(OP_ADDI));
        check("addi_rs1", alu_rs1, 32'd5);
        check("addi_rs2", alu_rs2, 32'd7);
        tick();
        check("addi_ov", 32'(out_valid), 32'd1);
        check("addi_tag", 32'(out_tag), 32'd3);
        check("addi_val", out_value, 32'd12);
        tick();
        check("addi_pulse", 32'(out_valid), 32'd0);

        // Pending operand resolved from bus B.
        set_issue(OP_ADD, 32'd0, 32'd1, 1'b1, 4'd2, 1'b0, 4'd0, 4'd5);
        tick();
        no_issue();
        check("wait_op0", 32'(alu_op), 32'd0);
        tick();
        check("wait_op1", 32'(alu_op), 32'd0);
        cdb_b_valid = 1'b1;
        cdb_b_tag = 4'd2;
        cdb_b_value = 32'd9;
        tick();
        cdb_b_valid = 1'b0;
        check("snoop_op", 32'(alu_op), 32'(OP_ADD));
        check("snoop_rs1", alu_rs1, 32'd9);
        tick();
        check("snoop_ov", 32'(out_valid), 32'd1);
        check("snoop_tag", 32'(out_tag), 32'd5);
        check("snoop_val", out_value, 32'd10);
        tick();
        check("snoop_pulse", 32'(out_valid), 32'd0);

        // Fill all entries, drop a ninth, release them together via bus A.
        for (int i = 0; i < RS; i++) begin
            set_issue(OP_ADD, 32'd0, 32'(i), 1'b1, 4'd6, 1'b0, 4'd0, 4'(8 + i));
            tick();
        end
        no_issue();
        check("fill_full", 32'(full_out), 32'd1);
        set_issue(OP_ADD, 32'd0, 32'd99, 1'b1, 4'd6, 1'b0, 4'd0, 4'd15);
        tick();
        no_issue();
        check("drop_full", 32'(full_out), 32'd1);
        check("drop_op", 32'(alu_op), 32'd0);
        tb_a_en = 1'b1;
        tb_a_valid = 1'b1;
        tb_a_tag = 4'd6;
        tb_a_value = 32'd100;
        tick();
        tb_a_en = 1'b0;
        tb_a_valid = 1'b0;
        check("fill_op", 32'(alu_op), 32'(OP_ADD));
        check("fill_rs1", alu_rs1, 32'd100);
        check("fill_rs2", alu_rs2, 32'd0);
        for (int i = 0; i < RS; i++) begin
            tick();
            if (i == 0) check("fill_unfull", 32'(full_out), 32'd0);
            check("fill_ov", 32'(out_valid), 32'd1);
            check("fill_tag", 32'(out_tag), 32'(8 + i));
            check("fill_val", out_value, 32'(100 + i));
        end
        tick();
        check("fill_done_ov", 32'(out_valid), 32'd0);
        check("fill_done_op", 32'(alu_op), 32'd0);

        // Dependent chain through the bus-A loopback.
        set_issue(OP_SUB, 32'd10, 32'd3, 1'b0, 4'd0, 1'b0, 4'd0, 4'd1);
        tick();
        set_issue(OP_XOR, 32'd0, 32'hF, 1'b1, 4'd1, 1'b0, 4'd0, 4'd2);
        #1;
        check("chain_sub_op", 32'(alu_op), 32'(OP_SUB));
        check("chain_sub_rs1", alu_rs1, 32'd10);
        tick();
        no_issue();
        check("chain_sub_ov", 32'(out_valid), 32'd1);
        check("chain_sub_tag", 32'(out_tag), 32'd1);
        check("chain_sub_val", out_value, 32'd7);
        check("chain_wait_op", 32'(alu_op), 32'd0);
        tick();
        check("chain_gap_ov", 32'(out_valid), 32'd0);
        check("chain_xor_op", 32'(alu_op), 32'(OP_XOR));
        check("chain_xor_rs1", alu_rs1, 32'd7);
        tick();
        check("chain_xor_ov", 32'(out_valid), 32'd1);
        check("chain_xor_tag", 32'(out_tag), 32'd2);
        check("chain_xor_val", out_value, 32'h8);

        // Flush with three busy entries and one dispatching.
        set_issue(OP_ADD, 32'd0, 32'd0, 1'b1, 4'd9, 1'b0, 4'd0, 4'd5);
        tick();
        set_issue(OP_ADD, 32'd0, 32'd0, 1'b1, 4'd9, 1'b0, 4'd0, 4'd6);
        tick();
        set_issue(OP_ADD, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd4);
        tick();
        no_issue();
        check("clr_inflight", 32'(alu_op), 32'(OP_ADD));
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        check("clr_ov", 32'(out_valid), 32'd0);
        check("clr_full", 32'(full_out), 32'd0);
        check("clr_op", 32'(alu_op), 32'd0);
        cdb_b_valid = 1'b1;
        cdb_b_tag = 4'd9;
        cdb_b_value = 32'd1;
        tick();
        cdb_b_valid = 1'b0;
        check("clr_gone_op", 32'(alu_op), 32'd0);
        tick();
        check("clr_gone_ov", 32'(out_valid), 32'd0);

        // Freeze with rdy_in low.
        set_issue(OP_ADD, 32'd2, 32'd3, 1'b0, 4'd0, 1'b0, 4'd0, 4'd7);
        tick();
        set_issue(OP_XOR, 32'hF0, 32'h0F, 1'b0, 4'd0, 1'b0, 4'd0, 4'd8);
        tick();
        no_issue();
        check("rdy_pre_ov", 32'(out_valid), 32'd1);
        check("rdy_pre_val", out_value, 32'd5);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rdy_hold_ov", 32'(out_valid), 32'd1);
            check("rdy_hold_tag", 32'(out_tag), 32'd7);
            check("rdy_hold_val", out_value, 32'd5);
            check("rdy_hold_op", 32'(alu_op), 32'(OP_XOR));
        end
        rdy_in = 1'b1;
        tick();
        check("rdy_go_ov", 32'(out_valid), 32'd1);
        check("rdy_go_tag", 32'(out_tag), 32'd8);
        check("rdy_go_val", out_value, 32'hFF);
        tick();
        check("rdy_done_ov", 32'(out_valid), 32'd0);

        // Asynchronous reset in the middle of a broadcast.
        set_issue(OP_ADD, 32'd0, 32'd0, 1'b1, 4'd3, 1'b0, 4'd0, 4'd10);
        tick();
        set_issue(OP_ADD, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
        tick();
        no_issue();
        tick();
        check("mrst_pre_tag", 32'(out_tag), 32'd9);
        rst_in = 1'b1;
        #1;
        check("mrst_ov", 32'(out_valid), 32'd0);
        check("mrst_tag", 32'(out_tag), 32'd0);
        check("mrst_val", out_value, 32'd0);
        #2;
        rst_in = 1'b0;
        cdb_b_valid = 1'b1;
        cdb_b_tag = 4'd3;
        cdb_b_value = 32'd0;
        tick();
        cdb_b_valid = 1'b0;
        check("mrst_gone_op", 32'(alu_op), 32'd0);
        tick();
        check("mrst_gone_ov", 32'(out_valid), 32'd0);

        // Randomized run against the model.
        rst_in = 1'b1;
        #2;
        rst_in = 1'b0;
        for (int i = 0; i < RS; i++) begin
            m[i].busy = 1'b0; m[i].op = '0; m[i].vj = '0; m[i].vk = '0;
            m[i].pj = 1'b0; m[i].pk = 1'b0; m[i].qj = '0; m[i].qk = '0; m[i].dest = '0;
        end
        m_ov = 1'b0;
        m_ot = '0;
        m_oval = '0;
        tick();
        for (int cyc = 0; cyc < 400; cyc++) begin
            rdy_in = ($urandom_range(0, 9) != 0);
            clear_in = ($urandom_range(0, 49) == 0);
            issue_valid = ($urandom_range(0, 9) < 6);
            issue_op = 6'($urandom_range(0, 5));
            issue_vj = $urandom;
            issue_vk = $urandom;
            issue_qj_pend = 1'($urandom_range(0, 1));
            issue_qk_pend = 1'($urandom_range(0, 1));
            issue_qj = 4'($urandom_range(0, 7));
            issue_qk = 4'($urandom_range(0, 7));
            issue_dest = 4'($urandom_range(0, 15));
            cdb_b_valid = ($urandom_range(0, 9) < 4);
            cdb_b_tag = 4'($urandom_range(0, 7));
            cdb_b_value = $urandom;
            #1;
            s = model_sel();
            check("rnd_full", 32'(full_out), 32'(model_full()));
            check("rnd_op", 32'(alu_op), (s >= 0) ? 32'(m[s].op) : 32'd0);
            check("rnd_rs1", alu_rs1, (s >= 0) ? m[s].vj : 32'd0);
            check("rnd_rs2", alu_rs2, (s >= 0) ? m[s].vk : 32'd0);
            tick();
            model_update();
            check("rnd_ov", 32'(out_valid), 32'(m_ov));
            check("rnd_tag", 32'(out_tag), 32'(m_ot));
            check("rnd_val", out_value, m_oval);
        end

        rdy_in = 1'b1;
        clear_in = 1'b0;
        no_issue();
        cdb_b_valid = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
